// File: rtl/call_display_scanner.sv
// Call display scanner: multiplexed 4-digit 7-segment readout of the
// current call, post-call blink sequence and waiting-ticket count.
module call_display_scanner #(
    parameter int SCAN_DIV      = 50000,
    parameter int BLINK_TICKS   = 100,
    parameter int BLINK_TOGGLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       call_valid,
    input  logic [3:0] call_counter,
    input  logic [5:0] call_number,
    input  logic [5:0] max_call_number,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       blinking,
    output logic [5:0] waiting
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam int TW = $clog2(BLINK_TOGGLES + 1);

    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BT_MAX    = BW'(BLINK_TICKS - 1);
    localparam logic [TW-1:0] TOG_LAST  = TW'(BLINK_TOGGLES - 1);

    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        BL_IDLE,
        BL_OFF,
        BL_ON
    } blink_e;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    digit_q, digit_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [5:0]    num_q, num_d;
    logic          shown_q, shown_d;
    blink_e        state_q, state_d;
    logic [BW-1:0] btick_q, btick_d;
    logic [TW-1:0] tog_q, tog_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          blink_q, blink_d;
    logic [5:0]    wait_q, wait_d;

    logic          tick;
    logic [1:0]    nxt_digit;
    logic [3:0]    tens, ones;
    logic [6:0]    scan_glyph;

    function automatic logic [6:0] num_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = G_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] ctr_glyph(input logic [3:0] id);
        logic [6:0] g;
        case (id)
            4'd1:    g = 7'b0001000;
            4'd2:    g = 7'b0000011;
            4'd3:    g = 7'b1000110;
            4'd4:    g = 7'b0100001;
            4'd5:    g = 7'b0000110;
            default: g = G_DASH;
        endcase
        return g;
    endfunction

    assign tick      = (presc_q == PRESC_MAX);
    assign nxt_digit = digit_q + 2'd1;
    assign tens      = 4'(num_q / 6'd10);
    assign ones      = 4'(num_q % 6'd10);

    // Glyph for the digit the scan moves to on the next tick (old latch).
    always_comb begin
        scan_glyph = G_DASH;
        if (shown_q) begin
            case (nxt_digit)
                2'd3: scan_glyph = ctr_glyph(cnt_q);
                2'd2: scan_glyph = G_BLANK;
                2'd1: scan_glyph = (num_q < 6'd10) ? G_BLANK
                                                   : num_glyph(tens);
                default: scan_glyph = num_glyph(ones);
            endcase
        end
    end

    // Next-state: prescaler, scan, call latch, blink sequencer, outputs.
    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        digit_d = tick ? nxt_digit : digit_q;
        cnt_d   = cnt_q;
        num_d   = num_q;
        shown_d = shown_q;
        state_d = state_q;
        btick_d = btick_q;
        tog_d   = tog_q;
        seg_d   = tick ? scan_glyph : seg_q;

        if (call_valid) begin
            cnt_d   = call_counter;
            num_d   = call_number;
            shown_d = 1'b1;
            state_d = BL_OFF;
            btick_d = '0;
            tog_d   = '0;
        end else if (state_q != BL_IDLE && tick) begin
            if (btick_q == BT_MAX) begin
                btick_d = '0;
                tog_d   = tog_q + TW'(1);
                if (tog_q == TOG_LAST) begin
                    state_d = BL_IDLE;
                end else begin
                    state_d = (state_q == BL_OFF) ? BL_ON : BL_OFF;
                end
            end else begin
                btick_d = btick_q + BW'(1);
            end
        end

        an_d    = (state_d == BL_OFF) ? 4'b1111 : ~(4'b0001 << digit_d);
        blink_d = (state_d != BL_IDLE);
        wait_d  = shown_q ? (max_call_number - num_q) : 6'd0;
    end

    // State and registered outputs, asynchronously cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= '0;
            digit_q <= 2'd0;
            cnt_q   <= 4'd0;
            num_q   <= 6'd0;
            shown_q <= 1'b0;
            state_q <= BL_IDLE;
            btick_q <= '0;
            tog_q   <= '0;
            seg_q   <= G_DASH;
            an_q    <= 4'b1110;
            blink_q <= 1'b0;
            wait_q  <= 6'd0;
        end else begin
            presc_q <= presc_d;
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            num_q   <= num_d;
            shown_q <= shown_d;
            state_q <= state_d;
            btick_q <= btick_d;
            tog_q   <= tog_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            blink_q <= blink_d;
            wait_q  <= wait_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign blinking = blink_q;
    assign waiting  = wait_q;

endmodule

// File: tb/tb_call_display_scanner.sv
// Bench for call_display_scanner: scoreboard of expected display frames
// checked at scan ticks, plus per-cycle blink checks and async reset.
module tb_call_display_scanner;

    localparam int SD   = 2;
    localparam int BT   = 4;
    localparam int BTG  = 6;
    localparam int HALF = SD * BT;
    localparam int TOT  = SD * BT * BTG;

    localparam logic [6:0] DASH  = 7'b0111111;
    localparam logic [6:0] BLANK = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       call_valid = 1'b0;
    logic [3:0] call_counter = 4'd0;
    logic [5:0] call_number = 6'd0;
    logic [5:0] max_call_number = 6'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       blinking;
    logic [5:0] waiting;

    call_display_scanner #(
        .SCAN_DIV(SD),
        .BLINK_TICKS(BT),
        .BLINK_TOGGLES(BTG)
    ) dut (
        .clk(clk),
        .rst(rst),
        .call_valid(call_valid),
        .call_counter(call_counter),
        .call_number(call_number),
        .max_call_number(max_call_number),
        .seg(seg),
        .an(an),
        .blinking(blinking),
        .waiting(waiting)
    );

    always #5 clk = ~clk;

    int ecnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) ecnt <= 0;
        else      ecnt <= ecnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic       m_shown = 1'b0;
    logic [3:0] m_cnt   = 4'd0;
    logic [5:0] m_num   = 6'd0;
    int         m_bstart = -1;

    typedef struct {
        int         e;
        logic [3:0] an;
        logic [6:0] seg;
        logic       blink;
    } frame_t;

    frame_t sb[$];

    function automatic logic [6:0] g_num(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return BLANK;
        endcase
    endfunction

    function automatic logic [6:0] g_ctr(input logic [3:0] id);
        case (id)
            4'd1: return 7'b0001000;
            4'd2: return 7'b0000011;
            4'd3: return 7'b1000110;
            4'd4: return 7'b0100001;
            4'd5: return 7'b0000110;
            default: return DASH;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int d);
        int n;
        n = int'(m_num);
        if (!m_shown) return DASH;
        case (d)
            3: return g_ctr(m_cnt);
            2: return BLANK;
            1: return (n < 10) ? BLANK : g_num(n / 10);
            default: return g_num(n % 10);
        endcase
    endfunction

    function automatic logic exp_blink(input int e);
        return (m_bstart >= 0) && (e >= m_bstart) && (e - m_bstart < TOT);
    endfunction

    function automatic logic [3:0] exp_an(input int e);
        int d;
        d = (e / SD) % 4;
        if (exp_blink(e) && (((e - m_bstart) / HALF) % 2 == 0))
            return 4'b1111;
        return ~(4'b0001 << d);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_edge(input int target);
        int guard;
        guard = 0;
        while (ecnt < target && guard < 1000) begin
            step();
            guard++;
        end
        n_checks++;
        if (ecnt != target) begin
            n_fail++;
            $display("FAIL wait_edge: at edge %0d, required %0d", ecnt, target);
        end
    endtask

    task automatic do_call(input logic [3:0] c, input logic [5:0] n,
                           input logic [5:0] m);
        if (ecnt % SD == 0) step();
        call_counter    = c;
        call_number     = n;
        max_call_number = m;
        call_valid      = 1'b1;
        step();
        call_valid = 1'b0;
        m_shown  = 1'b1;
        m_cnt    = c;
        m_num    = n;
        m_bstart = ecnt;
    endtask

    task automatic push_frames(input int nf);
        int base;
        int e;
        frame_t f;
        base = ecnt + (ecnt % SD);
        for (int j = 1; j <= nf; j++) begin
            e       = base + SD * j;
            f.e     = e;
            f.an    = exp_an(e);
            f.seg   = exp_seg((e / SD) % 4);
            f.blink = exp_blink(e);
            sb.push_back(f);
        end
    endtask

    task automatic drain(input string tag);
        frame_t f;
        while (sb.size() > 0) begin
            f = sb.pop_front();
            wait_edge(f.e);
            n_checks++;
            if (an !== f.an) begin
                n_fail++;
                $display("FAIL %s an @%0d: got %b required %b",
                         tag, f.e, an, f.an);
            end
            n_checks++;
            if (seg !== f.seg) begin
                n_fail++;
                $display("FAIL %s seg @%0d: got %b required %b",
                         tag, f.e, seg, f.seg);
            end
            n_checks++;
            if (blinking !== f.blink) begin
                n_fail++;
                $display("FAIL %s blinking @%0d: got %b required %b",
                         tag, f.e, blinking, f.blink);
            end
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (seg !== DASH) begin
            n_fail++;
            $display("FAIL %s seg: got %b required %b", tag, seg, DASH);
        end
        n_checks++;
        if (an !== 4'b1110) begin
            n_fail++;
            $display("FAIL %s an: got %b required 1110", tag, an);
        end
        n_checks++;
        if (blinking !== 1'b0) begin
            n_fail++;
            $display("FAIL %s blinking: got %b required 0", tag, blinking);
        end
        n_checks++;
        if (waiting !== 6'd0) begin
            n_fail++;
            $display("FAIL %s waiting: got %0d required 0", tag, waiting);
        end
    endtask

    task automatic check_blink_cycles(input int until_e, input string tag);
        while (ecnt < until_e) begin
            step();
            n_checks++;
            if (an !== exp_an(ecnt)) begin
                n_fail++;
                $display("FAIL %s an @%0d: got %b required %b",
                         tag, ecnt, an, exp_an(ecnt));
            end
            n_checks++;
            if (blinking !== exp_blink(ecnt)) begin
                n_fail++;
                $display("FAIL %s blinking @%0d: got %b required %b",
                         tag, ecnt, blinking, exp_blink(ecnt));
            end
        end
    endtask

    task automatic check_waiting(input logic [5:0] req, input string tag);
        n_checks++;
        if (waiting !== req) begin
            n_fail++;
            $display("FAIL %s waiting: got %0d required %0d",
                     tag, waiting, req);
        end
    endtask

    task automatic test_reset();
        #23;
        check_idle_outputs("reset_held");
        @(posedge clk);
        #1;
        rst = 1'b1;
        check_idle_outputs("reset_release");
    endtask

    task automatic test_scan();
        push_frames(8);
        drain("scan");
        check_waiting(6'd0, "scan");
    endtask

    task automatic test_call();
        do_call(4'd2, 6'd23, 6'd25);
        step();
        check_waiting(6'd2, "call");
        push_frames(8);
        drain("call");
    endtask

    task automatic test_blink();
        int e1;
        do_call(4'd1, 6'd7, 6'd7);
        e1 = m_bstart;
        push_frames(4);
        drain("blink_first");
        check_blink_cycles(e1 + 19, "blink_first");
        do_call(4'd5, 6'd40, 6'd41);
        push_frames(4);
        drain("blink_restart");
        check_blink_cycles(m_bstart + TOT + 6, "blink_restart");
        check_waiting(6'd1, "blink_restart");
    endtask

    task automatic test_invalid_wrap();
        do_call(4'd9, 6'd63, 6'd1);
        step();
        check_waiting(6'd2, "wrap");
        push_frames(4);
        drain("invalid");
    endtask

    task automatic test_async_reset();
        do_call(4'd3, 6'd12, 6'd20);
        step();
        step();
        step();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        m_shown  = 1'b0;
        m_bstart = -1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        push_frames(4);
        drain("after_reset");
        check_waiting(6'd0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_call();
        test_blink();
        test_invalid_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t, required completion earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
